// File: rtl/status_flags_reg.sv
// ALU status flag register {N,Z,V,C} with per-flag write mask and condition-code evaluation.
// Optional sticky overflow flag enabled by defining STATUS_FLAGS_STICKY_EN.
module status_flags_reg #(
  parameter int unsigned N = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [3:0]       sel,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N:0]       res,
  input  logic [2*N-1:0]   prod,
  input  logic [3:0]       upd_mask,
  input  logic             clr_sticky,
  input  logic [3:0]       cc,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic             cond_true,
  output logic             valid_out
);

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_MUL = 4'd2;
  localparam logic [3:0] SEL_DIV = 4'd3;

  logic [N-1:0] r_c;
  logic         nxt_n;
  logic         nxt_z;
  logic         nxt_v;
  logic         nxt_c;
  logic [3:0]   nxt_flags;
  logic         unused_bits;

  // Next flag values from the current op result
  always_comb begin
    r_c   = (sel == SEL_MUL) ? prod[N-1:0] : res[N-1:0];
    nxt_n = r_c[N-1];
    nxt_z = (r_c == '0);
    nxt_v = 1'b0;
    nxt_c = 1'b0;
    case (sel)
      SEL_ADD: begin
        nxt_c = res[N];
        nxt_v = (A[N-1] == B[N-1]) && (r_c[N-1] != A[N-1]);
      end
      SEL_SUB: begin
        nxt_c = res[N];
        nxt_v = (A[N-1] != B[N-1]) && (r_c[N-1] != A[N-1]);
      end
      SEL_MUL: begin
        nxt_c = prod[2*N-1];
        nxt_v = |prod[2*N-1:N];
      end
      SEL_DIV: begin
        nxt_v = (B == '0);
      end
      default: begin
        nxt_v = 1'b0;
        nxt_c = 1'b0;
      end
    endcase
    nxt_flags = {nxt_n, nxt_z, nxt_v, nxt_c};
  end

  // Masked flag update and one-cycle valid echo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= 4'b0000;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        flags <= (flags & ~upd_mask) | (nxt_flags & upd_mask);
      end
    end
  end

`ifdef STATUS_FLAGS_STICKY_EN
  logic sticky_set;

  assign sticky_set  = valid_in & upd_mask[1] & nxt_v;
  assign unused_bits = ^A[N-2:0];

  // Set takes priority over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
    end else if (sticky_set) begin
      sticky_v <= 1'b1;
    end else if (clr_sticky) begin
      sticky_v <= 1'b0;
    end
  end
`else
  assign sticky_v    = 1'b0;
  assign unused_bits = ^{clr_sticky, A[N-2:0]};
`endif

  // Condition-code evaluation against the registered flags
  always_comb begin
    cond_true = 1'b0;
    case (cc)
      4'd0:    cond_true = flags[2];
      4'd1:    cond_true = !flags[2];
      4'd2:    cond_true = flags[0];
      4'd3:    cond_true = !flags[0];
      4'd4:    cond_true = flags[3];
      4'd5:    cond_true = !flags[3];
      4'd6:    cond_true = flags[1];
      4'd7:    cond_true = !flags[1];
      4'd8:    cond_true = flags[0] && !flags[2];
      4'd9:    cond_true = !flags[0] || flags[2];
      4'd10:   cond_true = (flags[3] == flags[1]);
      4'd11:   cond_true = (flags[3] != flags[1]);
      4'd12:   cond_true = !flags[2] && (flags[3] == flags[1]);
      4'd13:   cond_true = flags[2] || (flags[3] != flags[1]);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
